spi_mem_arbiter: RTL and testbench

Controller and arbiter placed behind the SPI slave. It decodes the 10-bit SPI receive word (2-bit command plus 8-bit payload) into address loads, memory writes and memory reads on an internal single-port RAM. It shares that RAM with a local host port. A round-robin arbiter serialises SPI and host accesses, and SPI read data is returned to the slave through tx_data/tx_valid.

---
 rtl/spi_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// SPI command decoder and RAM arbiter shared between the SPI slave and a local host port.
// Define HOST_FIXED_PRIO_EN to give the host fixed priority instead of round-robin.
module spi_mem_arbiter #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 spi_ovf
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSpi  = 2'd1,
    StHost = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 pend_valid_q, pend_valid_d;
  logic                 pend_we_q, pend_we_d;
  logic [ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]    pend_data_q, pend_data_d;
  logic                 ovf_q, ovf_d;
  logic                 tx_valid_q, host_gnt_q, host_rvalid_q;
  logic [DATA_W-1:0]    tx_data_q, host_rdata_q;
`ifndef HOST_FIXED_PRIO_EN
  logic                 last_host_q;
`endif

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [1:0] cmd;
  logic [7:0] payload;
  logic       spi_cmd, spi_own, host_own, spi_req;

  assign cmd      = rx_data[9:8];
  assign payload  = rx_data[7:0];
  assign spi_cmd  = rx_valid & cmd[0];
  assign spi_own  = (state_q == StSpi);
  assign host_own = (state_q == StHost);
  // A command arriving this cycle already counts as a request, saving a cycle of latency.
  assign spi_req  = pend_valid_q | spi_cmd;

  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    pend_valid_d = pend_valid_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    ovf_d        = ovf_q;
    if (spi_own) pend_valid_d = 1'b0;
    if (rx_valid) begin
      case (cmd)
        2'b00:   wr_addr_d = ADDR_SIZE'(payload);
        2'b10:   rd_addr_d = ADDR_SIZE'(payload);
        default: begin
          if (pend_valid_q && !spi_own) begin
            ovf_d = 1'b1;
          end else begin
            pend_valid_d = 1'b1;
            pend_we_d    = ~cmd[1];
            pend_addr_d  = cmd[1] ? rd_addr_q : wr_addr_q;
            pend_data_d  = DATA_W'(payload);
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (spi_req && host_req) begin
`ifdef HOST_FIXED_PRIO_EN
          state_d = StHost;
`else
          state_d = last_host_q ? StSpi : StHost;
`endif
        end else if (spi_req) begin
          state_d = StSpi;
        end else if (host_req) begin
          state_d = StHost;
        end
      end
      StSpi:   state_d = host_req ? StHost : StIdle;
      // host_req is not looked at here, so the host never gets two grants in a row.
      StHost:  state_d = spi_req ? StSpi : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      pend_valid_q  <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      ovf_q         <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
`ifndef HOST_FIXED_PRIO_EN
      last_host_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      pend_valid_q  <= pend_valid_d;
      pend_we_q     <= pend_we_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      ovf_q         <= ovf_d;
      host_gnt_q    <= (state_d == StHost);
      tx_valid_q    <= spi_own & ~pend_we_q;
      host_rvalid_q <= host_own & ~host_we;
      if (spi_own && !pend_we_q) tx_data_q <= mem[pend_addr_q];
      if (host_own && !host_we) host_rdata_q <= mem[host_addr];
`ifndef HOST_FIXED_PRIO_EN
      if (spi_own) begin
        last_host_q <= 1'b0;
      end else if (host_own) begin
        last_host_q <= 1'b1;
      end
`endif
    end
  end

  // RAM has no reset; accesses are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (spi_own && pend_we_q) begin
        mem[pend_addr_q] <= pend_data_q;
      end else if (host_own && host_we) begin
        mem[host_addr] <= host_wdata;
      end
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign host_gnt    = host_gnt_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign spi_ovf     = ovf_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_spi_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       spi_ovf;

  spi_mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .spi_ovf    (spi_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the RAM this cycle, a one-slot request queue,
  // and a sparse memory image with a known flag per word.
  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } pend_t;

  localparam int OwnIdle = 0;
  localparam int OwnSpi  = 1;
  localparam int OwnHost = 2;

  logic [7:0] m_mem [256];
  bit         m_known [256];
  pend_t      m_pend [$];
  logic [7:0] m_wr, m_rd;
  int         m_owner;
  bit         m_last_host;
  bit         m_valid = 1'b0;

  logic       e_tx_valid, e_gnt, e_rvalid, e_ovf;
  logic [7:0] e_tx_data, e_rdata;
  bit         e_tx_known, e_rknown;

  task automatic model_step();
    pend_t      p;
    int         nxt;
    logic [1:0] c;
    logic [7:0] pl;
    bit         spi_wants;
    if (!rst_n) begin
      e_tx_valid = 1'b0; e_tx_data = 8'h00; e_tx_known = 1'b1;
      e_gnt = 1'b0; e_rvalid = 1'b0; e_rdata = 8'h00; e_rknown = 1'b1; e_ovf = 1'b0;
      m_wr = 8'h00; m_rd = 8'h00; m_pend.delete();
      m_owner = OwnIdle; m_last_host = 1'b0; m_valid = 1'b1;
      return;
    end
    e_tx_valid = 1'b0;
    e_rvalid   = 1'b0;
    if (m_owner == OwnSpi && m_pend.size() != 0) begin
      p = m_pend.pop_front();
      if (p.we) begin
        m_mem[p.addr] = p.data; m_known[p.addr] = 1'b1;
      end else begin
        e_tx_valid = 1'b1; e_tx_data = m_mem[p.addr]; e_tx_known = m_known[p.addr];
      end
      m_last_host = 1'b0;
    end else if (m_owner == OwnHost) begin
      if (host_we) begin
        m_mem[host_addr] = host_wdata; m_known[host_addr] = 1'b1;
      end else begin
        e_rvalid = 1'b1; e_rdata = m_mem[host_addr]; e_rknown = m_known[host_addr];
      end
      m_last_host = 1'b1;
    end
    c  = rx_data[9:8];
    pl = rx_data[7:0];
    if (rx_valid) begin
      if (c == 2'b00) m_wr = pl;
      else if (c == 2'b10) m_rd = pl;
      else if (m_pend.size() != 0) e_ovf = 1'b1;
      else begin
        p.we = (c == 2'b01); p.addr = (c == 2'b01) ? m_wr : m_rd; p.data = pl;
        m_pend.push_back(p);
      end
    end
    spi_wants = (m_pend.size() != 0);
    nxt = OwnIdle;
    if (m_owner == OwnIdle) begin
      if (spi_wants && host_req) begin
`ifdef HOST_FIXED_PRIO_EN
        nxt = OwnHost;
`else
        nxt = m_last_host ? OwnSpi : OwnHost;
`endif
      end else if (spi_wants) nxt = OwnSpi;
      else if (host_req) nxt = OwnHost;
    end else if (m_owner == OwnSpi) begin
      nxt = host_req ? OwnHost : OwnIdle;
    end else begin
      nxt = spi_wants ? OwnSpi : OwnIdle;
    end
    m_owner = nxt;
    e_gnt   = (nxt == OwnHost);
  endtask

  // Compare on the falling edge, then advance the model with the inputs for the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chkb("tx_valid", tx_valid, e_tx_valid);
        if (e_tx_known) chk("tx_data", tx_data, e_tx_data);
        chkb("host_gnt", host_gnt, e_gnt);
        chkb("host_rvalid", host_rvalid, e_rvalid);
        if (e_rknown) chk("host_rdata", host_rdata, e_rdata);
        chkb("spi_ovf", spi_ovf, e_ovf);
      end
      model_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_rx(input logic [9:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  bit host_done;

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) step();
    chkb("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chkb("rst_ovf", spi_ovf, 1'b0);
    rst_n = 1'b1;

    // SPI write 0xA5 to address 5, then read it back.
    send_rx(10'h005); send_rx(10'h1A5); send_rx(10'h205); send_rx(10'h300);
    chkb("t1_tx_early", tx_valid, 1'b0);
    step();
    chkb("t1_tx_valid", tx_valid, 1'b1);
    chk("t1_tx_data", tx_data, 8'hA5);
    chkb("t1_no_gnt", host_gnt, 1'b0);
    step();
    chkb("t1_tx_pulse", tx_valid, 1'b0);

    // Host write then host read.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h3C;
    step();
    chkb("t2_wr_gnt", host_gnt, 1'b1);
    host_req = 1'b0;
    step();
    chkb("t2_gnt_low", host_gnt, 1'b0);
    host_req = 1'b1; host_we = 1'b0;
    step();
    chkb("t2_rd_gnt", host_gnt, 1'b1);
    host_req = 1'b0;
    step();
    chkb("t2_rvalid", host_rvalid, 1'b1);
    chk("t2_rdata", host_rdata, 8'h3C);
    step();
    chkb("t2_rvalid_pulse", host_rvalid, 1'b0);

    // Contention with last owner SPI: host first, SPI sees the new value.
    send_rx(10'h210); send_rx(10'h300);
    step();
    chk("t3_pre_read", tx_data, 8'h3C);
    rx_data = 10'h300; rx_valid = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h77;
    step();
    chkb("t3a_host_first", host_gnt, 1'b1);
    rx_valid = 1'b0; host_req = 1'b0;
    step();
    chkb("t3a_spi_second", host_gnt, 1'b0);
    step();
    chkb("t3a_tx_valid", tx_valid, 1'b1);
    chk("t3a_tx_data", tx_data, 8'h77);

    // Contention with last owner HOST.
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    step();
    host_req = 1'b0;
    step();
    chk("t3b_rdata", host_rdata, 8'h77);
    rx_data = 10'h300; rx_valid = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h99;
    step();
    rx_valid = 1'b0;
`ifdef HOST_FIXED_PRIO_EN
    chkb("t6_host_first", host_gnt, 1'b1);
    host_req = 1'b0;
    step();
    step();
    chkb("t6_tx_valid", tx_valid, 1'b1);
    chk("t6_tx_data", tx_data, 8'h99);
`else
    chkb("t3b_spi_first", host_gnt, 1'b0);
    step();
    chkb("t3b_host_second", host_gnt, 1'b1);
    chkb("t3b_tx_valid", tx_valid, 1'b1);
    chk("t3b_tx_data", tx_data, 8'h77);
    host_req = 1'b0;
`endif
    step();

    // Overflow: a pending write blocked by a host grant, then a read arrives.
    send_rx(10'h030);
    rx_data = 10'h300; rx_valid = 1'b1;
    step();
    rx_data = 10'h15A;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h21; host_wdata = 8'h11;
    step();
    chkb("t4_gnt", host_gnt, 1'b1);
    rx_data = 10'h300;
    step();
    rx_valid = 1'b0;
    chkb("t4_ovf", spi_ovf, 1'b1);
    step();
    host_req = 1'b0;
    repeat (3) step();
    chkb("t4_ovf_sticky", spi_ovf, 1'b1);

    // Reset while SPI owns the RAM; memory contents survive.
    send_rx(10'h300);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chkb("t5_tx_valid", tx_valid, 1'b0);
    chk("t5_tx_data", tx_data, 8'h00);
    chkb("t5_ovf", spi_ovf, 1'b0);
    chkb("t5_gnt", host_gnt, 1'b0);
    chk("t5_rdata", host_rdata, 8'h00);
    send_rx(10'h230); send_rx(10'h300);
    step();
    chkb("t5_read_valid", tx_valid, 1'b1);
    chk("t5_read_data", tx_data, 8'h5A);

    // Random traffic against the model.
    host_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data[9:8] = 2'($urandom_range(0, 3));
      rx_data[7:0] = rx_data[8] ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      if (host_gnt) begin
        host_done = 1'b1;
      end else if (host_done || !host_req) begin
        host_done = 1'b0;
        host_req  = ($urandom_range(0, 2) == 0);
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 8'($urandom_range(0, 15));
        host_wdata = 8'($urandom_range(0, 255));
      end
      step();
    end
    rst_n = 1'b1; rx_valid = 1'b0; host_req = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
